// File: rtl/csel_pipe_adder_if.sv
// Handshake bundle for csel_pipe_adder.
//   master: operand source + result consumer (drives in_valid/a/b/cin/out_ready)
//   slave : the adder (drives in_ready/out_valid/sum/cout)
interface csel_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/csel_pipe_adder.sv
// Two-stage pipelined carry-select adder with valid/ready on both sides.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.slave  : in_valid/in_ready/a/b/cin in, out_valid/out_ready/sum/cout out
// Stage 1 registers both candidate sums (carry-in 0 and 1) per BLOCK slice.
// Stage 2 walks the select chain and registers sum/cout.

// Per-slice candidate generator: both possible slice sums with their carries.
module csel_slice #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  output logic [BLOCK:0]   s0,
  output logic [BLOCK:0]   s1
);
  assign s0 = {1'b0, a} + {1'b0, b};
  assign s1 = {1'b0, a} + {1'b0, b} + (BLOCK+1)'(1);
endmodule

module csel_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input logic               clk,
  input logic               rst_n,
  csel_pipe_adder_if.slave  bus
);
  localparam int NB = WIDTH / BLOCK;

  if (BLOCK < 1 || BLOCK > WIDTH || (WIDTH % BLOCK) != 0) begin : g_bad_cfg
    $error("csel_pipe_adder: WIDTH must be a positive multiple of BLOCK");
  end

  // vld_pipe[1] = stage-1 valid, vld_pipe[2] = stage-2 valid (drives out_valid)
  logic [2:1]              vld_pipe;
  logic                    acc;
  logic                    s2_load;
  logic                    in_ready;

  logic [NB-1:0][BLOCK:0]  s0_d, s1_d;
  logic [NB-1:0][BLOCK:0]  s0_q, s1_q;
  logic                    cin_q;
  logic [WIDTH-1:0]        sum_d, sum_q;
  logic                    cout_d, cout_q;

  // Stage 2 may load when it is empty or its result leaves this cycle;
  // stage 1 may accept when it is empty or advances this cycle.
  assign s2_load  = vld_pipe[1] && (!vld_pipe[2] || bus.out_ready);
  assign in_ready = rst_n && (!vld_pipe[1] || s2_load);
  assign acc      = bus.in_valid && in_ready;

  for (genvar k = 0; k < NB; k++) begin : g_slice
    csel_slice #(.BLOCK(BLOCK)) u_slice (
      .a  (bus.a[k*BLOCK +: BLOCK]),
      .b  (bus.b[k*BLOCK +: BLOCK]),
      .s0 (s0_d[k]),
      .s1 (s1_d[k])
    );
  end

  // Carry select chain: each slice's incoming carry picks a candidate,
  // whose top bit becomes the next slice's carry.
  always_comb begin
    logic             carry;
    logic [BLOCK:0]   sel;
    sum_d  = '0;
    carry  = cin_q;
    sel    = '0;
    for (int k = 0; k < NB; k++) begin
      sel = carry ? s1_q[k] : s0_q[k];
      sum_d[k*BLOCK +: BLOCK] = sel[BLOCK-1:0];
      carry = sel[BLOCK];
    end
    cout_d = carry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s0_q     <= '0;
      s1_q     <= '0;
      cin_q    <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      vld_pipe[1] <= acc || (vld_pipe[1] && !s2_load);
      vld_pipe[2] <= s2_load || (vld_pipe[2] && !bus.out_ready);
      // Stage 1 only updates on accept, so it holds while stalled.
      if (acc) begin
        s0_q  <= s0_d;
        s1_q  <= s1_d;
        cin_q <= bus.cin;
      end
      // Output only changes on load, so it holds under backpressure.
      if (s2_load) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_pipe[2];
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule

// File: tb/tb_csel_pipe_adder.sv
module tb_csel_pipe_adder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  csel_pipe_adder_if #(.WIDTH(16)) b16 ();
  csel_pipe_adder_if #(.WIDTH(32)) b32 ();

  csel_pipe_adder #(.WIDTH(16), .BLOCK(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  csel_pipe_adder #(.WIDTH(32), .BLOCK(8)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));

  int n_chk = 0;
  int n_err = 0;
  logic [16:0] q16[$];
  logic [32:0] q32[$];
  logic [16:0] bb_exp[8];

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One directed add with out_ready high; checks exact 2-edge latency.
  task automatic add1(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic c, input logic [15:0] es, input logic ec);
    b16.a = a; b16.b = b; b16.cin = c; b16.in_valid = 1'b1;
    #1;
    chk({tag, "_rdy"}, 33'(b16.in_ready), 33'd1);
    tick();
    b16.in_valid = 1'b0;
    chk({tag, "_lat1"}, 33'(b16.out_valid), 33'd0);
    tick();
    chk({tag, "_vld"}, 33'(b16.out_valid), 33'd1);
    chk({tag, "_sum"}, 33'(b16.sum), 33'(es));
    chk({tag, "_cout"}, 33'(b16.cout), 33'(ec));
  endtask

  // One scoreboard cycle for both instances (inputs already driven).
  task automatic sb_cycle();
    #1;
    if (b16.out_valid && b16.out_ready) begin
      if (q16.size() == 0) chk("rnd16_underflow", 33'(q16.size()), 33'd1);
      else chk("rnd16", 33'({b16.cout, b16.sum}), 33'(q16.pop_front()));
    end
    if (b16.in_valid && b16.in_ready)
      q16.push_back({1'b0, b16.a} + {1'b0, b16.b} + 17'(b16.cin));
    if (b32.out_valid && b32.out_ready) begin
      if (q32.size() == 0) chk("rnd32_underflow", 33'(q32.size()), 33'd1);
      else chk("rnd32", {b32.cout, b32.sum}, q32.pop_front());
    end
    if (b32.in_valid && b32.in_ready)
      q32.push_back({1'b0, b32.a} + {1'b0, b32.b} + 33'(b32.cin));
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    b16.in_valid = 1'b0; b16.a = '0; b16.b = '0; b16.cin = 1'b0; b16.out_ready = 1'b1;
    b32.in_valid = 1'b0; b32.a = '0; b32.b = '0; b32.cin = 1'b0; b32.out_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_vld", 33'(b16.out_valid), 33'd0);
    chk("rst_sum", 33'(b16.sum), 33'd0);
    chk("rst_cout", 33'(b16.cout), 33'd0);
    chk("rst_rdy", 33'(b16.in_ready), 33'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk("rel_rdy", 33'(b16.in_ready), 33'd1);
    tick();

    // Basic and carry-ripple cases
    add1("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    add1("ripple1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    add1("ripple2", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    add1("ripple3", 16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0);
    tick();
    chk("idle_vld", 33'(b16.out_valid), 33'd0);

    // Back-to-back: 8 inputs, 8 consecutive outputs in order
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        b16.a = 16'(i * 16'h1357 + 16'hF00F);
        b16.b = 16'h2468 ^ 16'(i << 12);
        b16.cin = i[0];
        b16.in_valid = 1'b1;
        bb_exp[i] = {1'b0, b16.a} + {1'b0, b16.b} + 17'(b16.cin);
      end else begin
        b16.in_valid = 1'b0;
      end
      #1;
      if (i < 8) chk("b2b_rdy", 33'(b16.in_ready), 33'd1);
      if (i >= 2) begin
        chk("b2b_vld", 33'(b16.out_valid), 33'd1);
        chk("b2b_res", 33'({b16.cout, b16.sum}), 33'(bb_exp[i-2]));
      end
      tick();
    end
    chk("b2b_end", 33'(b16.out_valid), 33'd0);

    // Backpressure: 1+1, 2+2, 3+3 with out_ready low
    b16.out_ready = 1'b0; b16.cin = 1'b0;
    b16.a = 16'd1; b16.b = 16'd1; b16.in_valid = 1'b1;
    #1 chk("bp_rdy1", 33'(b16.in_ready), 33'd1);
    tick();
    b16.a = 16'd2; b16.b = 16'd2;
    #1 chk("bp_rdy2", 33'(b16.in_ready), 33'd1);
    tick();
    b16.a = 16'd3; b16.b = 16'd3;
    #1 chk("bp_full", 33'(b16.in_ready), 33'd0);
    chk("bp_sum2", 33'(b16.sum), 33'd2);
    tick();
    chk("bp_hold_rdy", 33'(b16.in_ready), 33'd0);
    chk("bp_hold_sum", 33'(b16.sum), 33'd2);
    chk("bp_hold_vld", 33'(b16.out_valid), 33'd1);
    b16.out_ready = 1'b1;
    #1 chk("bp_rel_rdy", 33'(b16.in_ready), 33'd1);
    tick();
    b16.in_valid = 1'b0;
    chk("bp_out4", 33'(b16.sum), 33'd4);
    chk("bp_vld4", 33'(b16.out_valid), 33'd1);
    tick();
    chk("bp_out6", 33'(b16.sum), 33'd6);
    chk("bp_vld6", 33'(b16.out_valid), 33'd1);
    tick();
    chk("bp_drain", 33'(b16.out_valid), 33'd0);

    // Reset mid-flight
    b16.a = 16'h8001; b16.b = 16'h8002; b16.in_valid = 1'b1;
    tick();
    b16.a = 16'h0100; b16.b = 16'h0200;
    tick();
    b16.in_valid = 1'b0;
    chk("mf_pre_sum", 33'({b16.cout, b16.sum}), 33'h1_0003);
    #2 rst_n = 1'b0;
    #1;
    chk("mf_vld", 33'(b16.out_valid), 33'd0);
    chk("mf_sum", 33'(b16.sum), 33'd0);
    chk("mf_cout", 33'(b16.cout), 33'd0);
    chk("mf_rdy", 33'(b16.in_ready), 33'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("mf_stale", 33'(b16.out_valid), 33'd0);
      tick();
    end

    // Random traffic on both configurations
    for (int cyc = 0; cyc < 10000; cyc++) begin
      b16.in_valid  = ($urandom_range(0, 3) != 0);
      b16.out_ready = ($urandom_range(0, 3) != 0);
      b16.a = 16'($urandom); b16.b = 16'($urandom); b16.cin = 1'($urandom_range(0, 1));
      b32.in_valid  = ($urandom_range(0, 3) != 0);
      b32.out_ready = ($urandom_range(0, 3) != 0);
      b32.a = $urandom; b32.b = $urandom; b32.cin = 1'($urandom_range(0, 1));
      sb_cycle();
    end
    b16.in_valid = 1'b0; b16.out_ready = 1'b1;
    b32.in_valid = 1'b0; b32.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) sb_cycle();
    chk("q16_drain", 33'(q16.size()), 33'd0);
    chk("q32_drain", 33'(q32.size()), 33'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
